// File: rtl/gnn_result_collector.sv
// gnn_result_collector: sink for the accelerator's layer-2 results.
// Captures each slot's word on the rising edge of its ready level. Once the
// whole frame is present, it streams the slots in index order over a
// valid/ready word stream.
// Optional build macro: GNN_COLLECT_TIMEOUT_EN adds a collect watchdog
// (err_timeout). When the watchdog fires it forces a drain, and uncaptured
// slots are streamed as zero.
//
// Stream handshake: a word transfers on a rising clk edge where
// m_valid & m_ready. While m_valid is high and m_ready is low, m_data, m_idx
// and m_last hold steady. m_valid is never withdrawn until its word has
// transferred.
module gnn_result_collector #(
  parameter int NUM_NODES = 4,
  parameter int NUM_OUT   = 2,
  parameter int DW        = 21
`ifdef GNN_COLLECT_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NODES*NUM_OUT*DW-1:0]   res_data,
  input  logic [NUM_NODES*NUM_OUT-1:0]      res_ready,
  output logic [DW-1:0]                     m_data,
  output logic [$clog2(NUM_NODES*NUM_OUT)-1:0] m_idx,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              m_last,
  output logic                              frame_done,
  output logic                              busy,
  output logic                              err_overrun,
`ifdef GNN_COLLECT_TIMEOUT_EN
  output logic                              err_timeout,
`endif
  input  logic                              clr_err,
  output logic                              dbg_state
);

  localparam int NS = NUM_NODES * NUM_OUT;
  localparam int IW = $clog2(NS);

  typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [NS-1:0]   prev_q;
  logic [NS-1:0]   cap_q, cap_d;
  logic [NS-1:0]   rise;
  logic [DW-1:0]   data_q [NS];
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            fd_q, fd_d;
  logic            ovr_q, ovr_d, ovr_set;
  logic            xfer, last_slot;

`ifdef GNN_COLLECT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            to_q, to_d, to_set;
`endif

  assign rise      = res_ready & ~prev_q;
  assign last_slot = (ptr_q == IW'(NS - 1));
  assign xfer      = (state_q == DRAIN) && m_ready;

  // Ready history for edge detection, sampled every cycle in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= '0;
    else     prev_q <= res_ready;
  end

  // Result buffer: only the first rise of an uncaptured slot writes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NS; k++) data_q[k] <= '0;
    end else if (state_q == COLLECT) begin
      for (int k = 0; k < NS; k++)
        if (rise[k] && !cap_q[k]) data_q[k] <= res_data[k*DW +: DW];
    end
  end

  // Next-state logic for the collect/drain FSM and the error flags.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    ptr_d   = ptr_q;
    fd_d    = 1'b0;
    ovr_set = 1'b0;
`ifdef GNN_COLLECT_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_set  = 1'b0;
`endif
    case (state_q)
      COLLECT: begin
        cap_d   = cap_q | rise;
        ovr_set = |(rise & cap_q);
        ptr_d   = '0;
        if (&cap_d) state_d = DRAIN;
`ifdef GNN_COLLECT_TIMEOUT_EN
        if (&cap_d) begin
          cnt_d = '0;
        end else if (|cap_q) begin
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            to_set  = 1'b1;
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end
      DRAIN: begin
        ovr_set = |rise;
        if (xfer) begin
          if (last_slot) begin
            state_d = COLLECT;
            cap_d   = '0;
            ptr_d   = '0;
            fd_d    = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
    // A new error in the same cycle as a clear keeps the flag set.
    ovr_d = ovr_set ? 1'b1 : (clr_err ? 1'b0 : ovr_q);
`ifdef GNN_COLLECT_TIMEOUT_EN
    to_d  = to_set ? 1'b1 : (clr_err ? 1'b0 : to_q);
`endif
  end

  // State, capture flags, read pointer, done pulse and sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      cap_q   <= '0;
      ptr_q   <= '0;
      fd_q    <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef GNN_COLLECT_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      ptr_q   <= ptr_d;
      fd_q    <= fd_d;
      ovr_q   <= ovr_d;
`ifdef GNN_COLLECT_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  // Stream outputs are decoded from registered state only.
  // Uncaptured slots read as zero.
  assign m_valid     = (state_q == DRAIN);
  assign busy        = (state_q == DRAIN);
  assign m_idx       = ptr_q;
  assign m_last      = m_valid && last_slot;
  assign m_data      = (m_valid && cap_q[ptr_q]) ? data_q[ptr_q] : '0;
  assign frame_done  = fd_q;
  assign err_overrun = ovr_q;
  assign dbg_state   = state_q;
`ifdef GNN_COLLECT_TIMEOUT_EN
  assign err_timeout = to_q;
`endif

endmodule
